bus_master_if: RTL and testbench
================================

Name: bus_master_if

Overview:
- Master-side bus interface: the requesting end of the 4-master arbitrated bus.
- Accepts single read/write accesses from a CPU-side port.
- Requests the bus from the arbiter (active-low req_/grnt_) and waits for grant.
- Runs one address-strobe/ready-handshake transfer to a slave, then releases the bus. One instance per master (m0..m3).

Parameters:
ADDR_W, 30, word address width
DATA_W, 32, data width
TIMEOUT, 255, max WAIT cycles without bus_rdy_ before abort; 0 disables timeout

Ports:
clk  in  1  clock
reset  in  1  reset
cpu_req  in  1  access request, held high until stall low
cpu_rw  in  1  1=read, 0=write
cpu_addr  in  ADDR_W  access word address
cpu_wr_data  in  DATA_W  write data
cpu_rd_data  out  DATA_W  read data, valid in completion cycle and held after
stall  out  1  CPU must hold request while high
err  out  1  1-cycle pulse on timeout abort
bus_req_  out  1  bus request to arbiter, active-low
bus_grnt_  in  1  grant from arbiter, active-low
bus_as_  out  1  address strobe, active-low
bus_rw  out  1  1=read, 0=write
bus_addr  out  ADDR_W  bus address
bus_wr_data  out  DATA_W  bus write data
bus_rd_data  in  DATA_W  slave read data
bus_rdy_  in  1  slave ready, active-low

Behaviour:
- Reset: reset, synchronous, active-high; clock clk.
- Reset values: state=IDLE, bus_req_=1, bus_as_=1, bus_rw=1, bus_addr=0, bus_wr_data=0, cpu_rd_data=0, err=0, timeout counter=0.
- FSM states:
  - IDLE: if cpu_req=1, latch cpu_rw/addr/wr_data into the bus_* registers, set bus_req_=0, go to REQ.
  - REQ: bus_req_ stays 0. If bus_grnt_=0, set bus_as_=0 and go to ACCESS. Otherwise remain in REQ with no limit.
  - ACCESS: bus_as_=0 for exactly one cycle. Next state is WAIT with bus_as_=1 and counter cleared.
  - WAIT: bus_req_ stays 0 (holds grant); address, rw and data held stable.
    - bus_rdy_=0: completion. For a read, latch bus_rd_data. Next edge: bus_req_=1, state IDLE.
    - Else, if TIMEOUT≠0 and counter==TIMEOUT-1: abort. Pulse err=1 for one cycle, cpu_rd_data=0, bus_req_=1, state IDLE.
    - Otherwise counter+1.
- stall = cpu_req AND NOT(completion or abort this cycle). Combinational, so stall=1 in the same cycle cpu_req first rises in IDLE.
- cpu_rd_data is combinational bus_rd_data during a read completion cycle, so the CPU samples it at that edge. Afterwards it holds the registered value. Writes do not change it.
- Latency, zero-wait slave, grant already owned: cpu_req at cycle 0, REQ at 1, ACCESS at 2, WAIT/completion at 3. stall low in cycle 3.
- Back-to-back: a new request is seen in IDLE the cycle after completion. bus_req_ is high for at least one cycle between transfers so the arbiter can rotate.
- cpu_req dropping after IDLE is ignored; the latched transfer completes. stall then reads 0.
- bus_rdy_ is ignored outside WAIT. bus_grnt_ is ignored outside REQ.
- Reset asserted in any state returns to IDLE at the next edge with bus_req_=1 and bus_as_=1. No err pulse.

Test Plan:
- Read, grant immediate, rdy_ low on first WAIT cycle, addr=0x0000_0100, bus_rd_data=0xDEADBEEF → bus_as_ low in cycle 2 only; cpu_rd_data=0xDEADBEEF and stall=0 in cycle 3; bus_req_=1 in cycle 4.
- Write 0x12345678 to 0x3FFF_FFFF, grant delayed 5 cycles, slave 2 wait states → bus_addr/bus_wr_data/bus_rw=0 stable from ACCESS to completion; stall high for 9 cycles; cpu_rd_data unchanged.
- TIMEOUT=4, slave never responds → err=1 for exactly one cycle 4 WAIT cycles after ACCESS; cpu_rd_data=0; bus_req_=1 next cycle; state IDLE.
- Two back-to-back reads (cpu_req held) → bus_req_ high for exactly one cycle between transfers; second transfer uses the updated cpu_addr.
- Reset pulsed during WAIT with rdy_ later asserted → IDLE next edge, bus_req_=1, bus_as_=1, err=0; late rdy_ ignored.
- cpu_req dropped in REQ → transfer still completes on grant; stall=0 throughout the remainder.

Source files
------------

// File: rtl/bus_master_if.sv
// ---------------------------------------------------------------------------
// bus_master_if
//
// Master-side interface for the 4-master arbitrated bus. A CPU-side port
// issues single read or write accesses. For each access this block requests
// the bus from the arbiter, waits for grant, runs one address-strobe /
// ready-handshake transfer to a slave and then releases the bus. One instance
// sits in front of each master (m0..m3).
//
// Parameters:
//   ADDR_W   word address width
//   DATA_W   data width
//   TIMEOUT  max WAIT cycles without bus_rdy_ before the transfer is aborted;
//            0 disables the timeout
//
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   cpu_req       access request, held high by the CPU until stall drops
//   cpu_rw        1 = read, 0 = write
//   cpu_addr      access word address
//   cpu_wr_data   write data
//   cpu_rd_data   read data; live slave data in the read completion cycle,
//                 then the registered copy
//   stall         CPU must hold its request while this is high
//   err           one-cycle pulse after a timeout abort
//   bus_req_      bus request to the arbiter (active-low)
//   bus_grnt_     grant from the arbiter (active-low)
//   bus_as_       address strobe (active-low)
//   bus_rw        bus direction, 1 = read, 0 = write
//   bus_addr      bus address
//   bus_wr_data   bus write data
//   bus_rd_data   slave read data
//   bus_rdy_      slave ready (active-low)
// ---------------------------------------------------------------------------
module bus_master_if #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              stall,
    output logic              err,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_
);

    // The wait counter only has to reach TIMEOUT-1, so $clog2(TIMEOUT) bits
    // are enough; with the timeout disabled it just free-runs harmlessly.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACCESS,
        WAIT
    } state_t;

    state_t              state;
    state_t              state_d;
    logic                bus_req_d;
    logic                bus_as_d;
    logic                bus_rw_d;
    logic [ADDR_W-1:0]   bus_addr_d;
    logic [DATA_W-1:0]   bus_wr_data_d;
    logic [DATA_W-1:0]   rd_data_q;
    logic [DATA_W-1:0]   rd_data_d;
    logic                err_d;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_d;
    logic                completion;
    logic                abort;

    // A transfer ends either when the slave answers during WAIT or when the
    // slave has been silent for TIMEOUT cycles. Both are visible in the very
    // cycle they happen so the CPU can be released at that same edge.
    assign completion = (state == WAIT) && !bus_rdy_;
    assign abort      = (state == WAIT) && bus_rdy_ && (TIMEOUT != 0) && (cnt == CNT_LAST);

    // The CPU is stalled for as long as it requests and the transfer has not
    // ended this cycle. A request dropped after IDLE no longer stalls anything.
    assign stall = cpu_req && !(completion || abort);

    // Read data goes straight through from the slave in the completion cycle
    // so the CPU can capture it on that edge; otherwise the registered copy
    // is presented, which writes never disturb.
    assign cpu_rd_data = (completion && bus_rw) ? bus_rd_data : rd_data_q;

    // Next-state and next-register logic. Everything defaults to holding its
    // value, so the address, direction and write data stay stable from the
    // moment they are latched in IDLE until the bus is released. bus_req_ is
    // kept low from REQ through WAIT so the grant is held for the whole
    // transfer, and it always returns high for at least one IDLE cycle so the
    // arbiter gets a chance to rotate.
    always_comb begin
        state_d       = state;
        bus_req_d     = bus_req_;
        bus_as_d      = bus_as_;
        bus_rw_d      = bus_rw;
        bus_addr_d    = bus_addr;
        bus_wr_data_d = bus_wr_data;
        rd_data_d     = rd_data_q;
        err_d         = 1'b0;
        cnt_d         = cnt;
        unique case (state)
            IDLE: begin
                if (cpu_req) begin
                    bus_rw_d      = cpu_rw;
                    bus_addr_d    = cpu_addr;
                    bus_wr_data_d = cpu_wr_data;
                    bus_req_d     = 1'b0;
                    state_d       = REQ;
                end
            end
            REQ: begin
                if (!bus_grnt_) begin
                    bus_as_d = 1'b0;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                bus_as_d = 1'b1;
                cnt_d    = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                if (completion) begin
                    if (bus_rw) begin
                        rd_data_d = bus_rd_data;
                    end
                    bus_req_d = 1'b1;
                    state_d   = IDLE;
                end else if (abort) begin
                    err_d     = 1'b1;
                    rd_data_d = '0;
                    bus_req_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                bus_req_d = 1'b1;
                bus_as_d  = 1'b1;
                state_d   = IDLE;
            end
        endcase
    end

    // State and bus registers. Reset is synchronous and forces the bus
    // signals back to their idle levels from any state without an err pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bus_req_    <= 1'b1;
            bus_as_     <= 1'b1;
            bus_rw      <= 1'b1;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            rd_data_q   <= '0;
            err         <= 1'b0;
            cnt         <= '0;
        end else begin
            state       <= state_d;
            bus_req_    <= bus_req_d;
            bus_as_     <= bus_as_d;
            bus_rw      <= bus_rw_d;
            bus_addr    <= bus_addr_d;
            bus_wr_data <= bus_wr_data_d;
            rd_data_q   <= rd_data_d;
            err         <= err_d;
            cnt         <= cnt_d;
        end
    end

endmodule

// File: tb/tb_bus_master_if.sv
// ---------------------------------------------------------------------------
// tb_bus_master_if
//
// Self-checking bench for bus_master_if (TIMEOUT = 4). A small arbiter model
// grants after a programmable number of extra REQ cycles, and a small slave
// model answers after a programmable number of wait states (or not at all,
// when the test drives bus_rdy_ by hand). Every issued access pushes its
// expected outcome into a scoreboard queue; a monitor pops one entry each
// time the master releases the bus and compares what it saw on the bus and
// at the CPU port. Cycle-exact behaviour is checked inline by the stimulus.
// ---------------------------------------------------------------------------
module tb_bus_master_if;

    localparam int ADDR_W  = 30;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic              clk;
    logic              reset;
    logic              cpu_req;
    logic              cpu_rw;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wr_data;
    logic [DATA_W-1:0] cpu_rd_data;
    logic              stall;
    logic              err;
    logic              bus_req_;
    logic              bus_grnt_;
    logic              bus_as_;
    logic              bus_rw;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wr_data;
    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_rdy_;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              rw;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rd;
        logic              err;
    } expect_t;

    expect_t sb[$];

    int checks   = 0;
    int failures = 0;

    int   grant_extra = 0;
    int   slave_waits = 0;
    logic slave_auto  = 1'b1;
    logic auto_rdy_   = 1'b1;
    logic manual_rdy_ = 1'b1;
    logic [DATA_W-1:0] slave_rd = '0;

    bus_master_if #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_rw     (cpu_rw),
        .cpu_addr   (cpu_addr),
        .cpu_wr_data(cpu_wr_data),
        .cpu_rd_data(cpu_rd_data),
        .stall      (stall),
        .err        (err),
        .bus_req_   (bus_req_),
        .bus_grnt_  (bus_grnt_),
        .bus_as_    (bus_as_),
        .bus_rw     (bus_rw),
        .bus_addr   (bus_addr),
        .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data),
        .bus_rdy_   (bus_rdy_)
    );

    assign bus_rdy_    = slave_auto ? auto_rdy_ : manual_rdy_;
    assign bus_rd_data = slave_rd;

    // 10 ns clock; inputs change 1 ns after the rising edge and outputs are
    // sampled on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something never returns.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "[TB] watchdog");
    end

    // Compare one observed value against its expected value and keep count.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, actual, expected);
        end
    endtask

    // Present a new access at the CPU port and record what it must produce.
    task automatic applyStimulus(input logic rw, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata,
                                 input logic [DATA_W-1:0] exp_rd,
                                 input logic exp_err);
        expect_t e;
        cpu_req     = 1'b1;
        cpu_rw      = rw;
        cpu_addr    = addr;
        cpu_wr_data = wdata;
        e.addr  = addr;
        e.rw    = rw;
        e.wdata = wdata;
        e.rd    = exp_rd;
        e.err   = exp_err;
        sb.push_back(e);
    endtask

    task automatic cycleEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Arbiter model: once bus_req_ is low, grant after grant_extra further
    // cycles; drop the grant as soon as the request goes away.
    initial begin
        int gcnt;
        gcnt      = 0;
        bus_grnt_ = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bus_req_ !== 1'b0) begin
                gcnt      = 0;
                bus_grnt_ = 1'b1;
            end else if (gcnt >= grant_extra) begin
                bus_grnt_ = 1'b0;
            end else begin
                gcnt++;
            end
        end
    end

    // Slave model: after seeing the address strobe, hold bus_rdy_ high for
    // slave_waits WAIT cycles, then pulse it low for one cycle.
    initial begin
        int   wcnt;
        logic active;
        wcnt   = 0;
        active = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            auto_rdy_ = 1'b1;
            if (bus_req_ !== 1'b0) begin
                active = 1'b0;
            end else if (bus_as_ === 1'b0) begin
                active = 1'b1;
                wcnt   = 0;
            end else if (active) begin
                if (wcnt == slave_waits) begin
                    auto_rdy_ = 1'b0;
                    active    = 1'b0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Monitor: remember what the strobe put on the bus, and whenever the
    // master releases the bus check that transfer against the scoreboard.
    initial begin
        logic              prev_req_;
        logic [ADDR_W-1:0] obs_addr;
        logic              obs_rw;
        logic [DATA_W-1:0] obs_wdata;
        expect_t           e;
        prev_req_ = 1'b1;
        obs_addr  = '0;
        obs_rw    = 1'b1;
        obs_wdata = '0;
        forever begin
            @(negedge clk);
            if (bus_as_ === 1'b0) begin
                obs_addr  = bus_addr;
                obs_rw    = bus_rw;
                obs_wdata = bus_wr_data;
            end
            if (prev_req_ === 1'b0 && bus_req_ === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("sb_addr", 32'(obs_addr), 32'(e.addr));
                    checkOutput("sb_rw", 32'(obs_rw), 32'(e.rw));
                    if (!e.rw) begin
                        checkOutput("sb_wdata", obs_wdata, e.wdata);
                    end
                    checkOutput("sb_err", 32'(err), 32'(e.err));
                    checkOutput("sb_rd_data", cpu_rd_data, e.rd);
                end
            end
            prev_req_ = bus_req_;
        end
    end

    initial begin
        int   stall_cnt;
        logic done;
        logic strobe_seen;

        reset       = 1'b1;
        cpu_req     = 1'b0;
        cpu_rw      = 1'b1;
        cpu_addr    = '0;
        cpu_wr_data = '0;
        repeat (3) cycleEdge();
        reset = 1'b0;
        sample();
        checkOutput("rst_bus_req_", 32'(bus_req_), 32'd1);
        checkOutput("rst_bus_as_", 32'(bus_as_), 32'd1);
        checkOutput("rst_bus_rw", 32'(bus_rw), 32'd1);
        checkOutput("rst_bus_addr", 32'(bus_addr), 32'd0);
        checkOutput("rst_bus_wr_data", bus_wr_data, 32'd0);
        checkOutput("rst_cpu_rd_data", cpu_rd_data, 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);

        // Read, immediate grant, zero-wait slave: REQ c1, ACCESS c2, done c3.
        $display("[TB] read with immediate grant");
        slave_auto  = 1'b1;
        slave_waits = 0;
        grant_extra = 0;
        slave_rd    = 32'hDEADBEEF;
        cycleEdge();
        applyStimulus(1'b1, 30'h0000_0100, 32'h0, 32'hDEADBEEF, 1'b0);
        sample();
        checkOutput("t1_stall_c0", 32'(stall), 32'd1);
        checkOutput("t1_as_c0", 32'(bus_as_), 32'd1);
        cycleEdge();
        sample();
        checkOutput("t1_req_c1", 32'(bus_req_), 32'd0);
        checkOutput("t1_as_c1", 32'(bus_as_), 32'd1);
        cycleEdge();
        sample();
        checkOutput("t1_as_c2", 32'(bus_as_), 32'd0);
        checkOutput("t1_stall_c2", 32'(stall), 32'd1);
        cycleEdge();
        sample();
        checkOutput("t1_as_c3", 32'(bus_as_), 32'd1);
        checkOutput("t1_stall_c3", 32'(stall), 32'd0);
        checkOutput("t1_rd_c3", cpu_rd_data, 32'hDEADBEEF);
        cycleEdge();
        cpu_req = 1'b0;
        sample();
        checkOutput("t1_req_c4", 32'(bus_req_), 32'd1);

        // Write, grant in cycle 5, two slave wait states: done in cycle 9.
        $display("[TB] write with delayed grant and wait states");
        slave_waits = 2;
        grant_extra = 4;
        slave_rd    = 32'h0BAD0BAD;
        cycleEdge();
        applyStimulus(1'b0, 30'h3FFF_FFFF, 32'h12345678, 32'hDEADBEEF, 1'b0);
        stall_cnt   = 0;
        done        = 1'b0;
        strobe_seen = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            if (c > 0) cycleEdge();
            sample();
            if (stall) stall_cnt++;
            else done = 1'b1;
            if (!bus_as_) strobe_seen = 1'b1;
            if (strobe_seen) begin
                checkOutput("t2_addr_hold", 32'(bus_addr), 32'h3FFF_FFFF);
                checkOutput("t2_wdata_hold", bus_wr_data, 32'h12345678);
                checkOutput("t2_rw_hold", 32'(bus_rw), 32'd0);
            end
        end
        checkOutput("t2_done", 32'(done), 32'd1);
        checkOutput("t2_stall_cycles", 32'(stall_cnt), 32'd9);
        checkOutput("t2_rd_unchanged", cpu_rd_data, 32'hDEADBEEF);
        cycleEdge();
        cpu_req = 1'b0;
        sample();
        checkOutput("t2_req_after", 32'(bus_req_), 32'd1);

        // Slave never answers: WAIT c3..c6, abort in c6, err only in c7.
        $display("[TB] timeout abort");
        slave_auto  = 1'b0;
        manual_rdy_ = 1'b1;
        grant_extra = 0;
        cycleEdge();
        applyStimulus(1'b1, 30'h0000_0200, 32'h0, 32'h0, 1'b1);
        stall_cnt = 0;
        done      = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            if (c > 0) cycleEdge();
            sample();
            if (stall) stall_cnt++;
            else done = 1'b1;
        end
        checkOutput("t3_done", 32'(done), 32'd1);
        checkOutput("t3_abort_cycle", 32'(stall_cnt), 32'd6);
        checkOutput("t3_err_before", 32'(err), 32'd0);
        cycleEdge();
        cpu_req = 1'b0;
        sample();
        checkOutput("t3_err_pulse", 32'(err), 32'd1);
        checkOutput("t3_req_released", 32'(bus_req_), 32'd1);
        checkOutput("t3_rd_cleared", cpu_rd_data, 32'd0);
        cycleEdge();
        sample();
        checkOutput("t3_err_single", 32'(err), 32'd0);
        checkOutput("t3_idle", 32'(bus_req_), 32'd1);

        // Two back-to-back reads with cpu_req held throughout.
        $display("[TB] back-to-back reads");
        slave_auto  = 1'b1;
        slave_waits = 0;
        slave_rd    = 32'hCAFEF00D;
        cycleEdge();
        applyStimulus(1'b1, 30'h0000_0AAA, 32'h0, 32'hCAFEF00D, 1'b0);
        done = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            if (c > 0) cycleEdge();
            sample();
            if (!stall) done = 1'b1;
        end
        checkOutput("t4_first_done", 32'(done), 32'd1);
        checkOutput("t4_first_rd", cpu_rd_data, 32'hCAFEF00D);
        cycleEdge();
        applyStimulus(1'b1, 30'h0000_0BBB, 32'h0, 32'h0BADF00D, 1'b0);
        slave_rd = 32'h0BADF00D;
        sample();
        checkOutput("t4_gap_high", 32'(bus_req_), 32'd1);
        cycleEdge();
        sample();
        checkOutput("t4_gap_one_cycle", 32'(bus_req_), 32'd0);
        done = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            if (c > 0) cycleEdge();
            sample();
            if (!stall) done = 1'b1;
        end
        checkOutput("t4_second_done", 32'(done), 32'd1);
        checkOutput("t4_second_rd", cpu_rd_data, 32'h0BADF00D);
        cycleEdge();
        cpu_req = 1'b0;
        sample();

        // Reset during WAIT, then a late ready that must be ignored.
        $display("[TB] reset during wait");
        slave_auto  = 1'b0;
        manual_rdy_ = 1'b1;
        cycleEdge();
        applyStimulus(1'b1, 30'h0000_0055, 32'h0, 32'h0, 1'b0);
        repeat (3) cycleEdge();
        reset   = 1'b1;
        cpu_req = 1'b0;
        sample();
        checkOutput("t5_in_wait", 32'(bus_req_), 32'd0);
        cycleEdge();
        reset       = 1'b0;
        manual_rdy_ = 1'b0;
        sample();
        checkOutput("t5_req_idle", 32'(bus_req_), 32'd1);
        checkOutput("t5_as_idle", 32'(bus_as_), 32'd1);
        checkOutput("t5_err", 32'(err), 32'd0);
        cycleEdge();
        sample();
        checkOutput("t5_late_rdy_req", 32'(bus_req_), 32'd1);
        checkOutput("t5_late_rdy_err", 32'(err), 32'd0);
        checkOutput("t5_late_rdy_rd", cpu_rd_data, 32'd0);
        cycleEdge();
        manual_rdy_ = 1'b1;

        // cpu_req dropped while in REQ: transfer still runs, stall stays low.
        $display("[TB] request dropped in REQ");
        slave_auto  = 1'b1;
        slave_waits = 1;
        grant_extra = 2;
        slave_rd    = 32'hA5A55A5A;
        cycleEdge();
        applyStimulus(1'b1, 30'h0000_1234, 32'h0, 32'hA5A55A5A, 1'b0);
        sample();
        checkOutput("t6_stall_c0", 32'(stall), 32'd1);
        cycleEdge();
        cpu_req = 1'b0;
        done    = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            if (c > 0) cycleEdge();
            sample();
            checkOutput("t6_stall_low", 32'(stall), 32'd0);
            if (bus_req_) done = 1'b1;
        end
        checkOutput("t6_done", 32'(done), 32'd1);
        checkOutput("t6_rd", cpu_rd_data, 32'hA5A55A5A);

        repeat (2) cycleEdge();
        sample();
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
